// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the jogada replay block: FSM state encoding,
// RAM geometry and the LED colour-code to RGB palette.
package exibe_sequencia_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int RAM_W     = 4;
  localparam int ADDR_W    = 4;
  localparam int RGB_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ON    = 3'd3,
    ST_OFF   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Each LED line lights its own colour; several lit lines mix additively.
  function automatic logic [RGB_W-1:0] leds_to_rgb(input logic [RAM_W-1:0] code);
    logic [RGB_W-1:0] rgb;
    rgb = '0;
    if (code[0]) rgb = rgb | 3'b100;
    if (code[1]) rgb = rgb | 3'b010;
    if (code[2]) rgb = rgb | 3'b001;
    if (code[3]) rgb = rgb | 3'b110;
    return rgb;
  endfunction

endpackage

// File: rtl/exibe_sequencia_cores_rgb.sv
// Colour-code to RGB driver for the board LEDs; purely combinational so the
// RGB output follows the registered leds value with no extra latency.
module cores_rgb
  import exibe_sequencia_pkg::*;
(
  input  logic [RAM_W-1:0] leds,
  output logic [RGB_W-1:0] rgb
);

  assign rgb = leds_to_rgb(leds);

endmodule

// File: rtl/exibe_sequencia.sv
// Replays jogada RAM entries 0..limite on the LEDs with fixed on/off timing.
// One timer is reused for the ON and OFF phases; all outputs are registered.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON  = 2000,
  parameter int T_OFF = 500,
  parameter int TW    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] limite,
  input  logic [RAM_W-1:0]  ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_W-1:0]  leds,
  output logic [RGB_W-1:0]  rgb,
  output logic              led_on,
  output logic              busy,
  output logic              done
);

  localparam logic [TW-1:0] T_ON_M1  = TW'(T_ON - 1);
  localparam logic [TW-1:0] T_OFF_M1 = TW'(T_OFF - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [RAM_W-1:0]  colour_q, colour_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RAM_W-1:0]  leds_q, leds_d;
  logic              led_on_q, led_on_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    limit_d  = limit_q;
    colour_d = colour_q;
    timer_d  = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          limit_d = limite;
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        colour_d = ram_q;
        timer_d  = T_ON_M1;
        state_d  = ST_ON;
      end
      ST_ON: begin
        if (timer_q == '0) begin
          timer_d = T_OFF_M1;
          state_d = ST_OFF;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_OFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (addr_q == limit_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Cancel overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end

    leds_d   = (state_d == ST_ON) ? colour_d : '0;
    led_on_d = (state_d == ST_ON);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      limit_q  <= '0;
      colour_q <= '0;
      timer_q  <= '0;
      leds_q   <= '0;
      led_on_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      limit_q  <= limit_d;
      colour_q <= colour_d;
      timer_q  <= timer_d;
      leds_q   <= leds_d;
      led_on_q <= led_on_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ram_addr = addr_q;
  assign leds     = leds_q;
  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign done     = done_q;

  cores_rgb u_cores_rgb (
    .leds (leds_q),
    .rgb  (rgb)
  );

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia: a cycle trace is predicted per replay
// and a negedge monitor compares every cycle against it.
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int ENTRY = 2 + T_ON + T_OFF;

  logic       clock = 1'b0;
  logic       reset, start, abort;
  logic [3:0] limite, ram_q, ram_addr, leds;
  logic [2:0] rgb;
  logic       led_on, busy, done;

  logic [3:0] mem [16];

  typedef struct packed {
    logic [3:0] leds;
    logic [2:0] rgb;
    logic       led_on;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] idle_addr;
  logic       mon_en;
  int         n_checks;
  int         n_fail;

  exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TW(12)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .limite   (limite),
    .ram_q    (ram_q),
    .ram_addr (ram_addr),
    .leds     (leds),
    .rgb      (rgb),
    .led_on   (led_on),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Synchronous RAM read port: data valid one edge after the address.
  always @(posedge clock) ram_q <= mem[ram_addr];

  function automatic logic [2:0] palette(input logic [3:0] code);
    logic [2:0] mix;
    mix = 3'b000;
    if (code[0]) mix = mix | 3'b100;  // red
    if (code[1]) mix = mix | 3'b010;  // green
    if (code[2]) mix = mix | 3'b001;  // blue
    if (code[3]) mix = mix | 3'b110;  // yellow
    return mix;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected trace, one record per cycle after the start-sampling edge.
  task automatic push_replay(input int lim);
    exp_t r;
    for (int i = 0; i <= lim; i++) begin
      for (int c = 0; c < ENTRY; c++) begin
        r = '0;
        r.busy = 1'b1;
        r.addr = 4'(i);
        if (c >= 2 && c < 2 + T_ON) begin
          r.led_on = 1'b1;
          r.leds   = mem[i];
          r.rgb    = palette(mem[i]);
        end
        expq.push_back(r);
      end
    end
    r = '0;
    r.busy = 1'b1;
    r.done = 1'b1;
    r.addr = 4'(lim);
    expq.push_back(r);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.done) idle_addr = e.addr;
      end else begin
        e = '0;
        e.addr = idle_addr;
      end
      check("leds",     32'(leds),     32'(e.leds));
      check("rgb",      32'(rgb),      32'(e.rgb));
      check("led_on",   32'(led_on),   32'(e.led_on));
      check("busy",     32'(busy),     32'(e.busy));
      check("done",     32'(done),     32'(e.done));
      check("ram_addr", 32'(ram_addr), 32'(e.addr));
    end
  end

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (expq.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    if (expq.size() > 0) begin
      check("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    tick();
  endtask

  // One replay; optional abort at step ab_m, optional extra start pulse at st_m.
  task automatic run(input int lim, input int ab_m, input int st_m, input logic [3:0] st_lim);
    int n;
    n = (lim + 1) * ENTRY + 1;
    start  = 1'b1;
    limite = 4'(lim);
    tick();
    start  = 1'b0;
    push_replay(lim);
    for (int j = 0; j < n; j++) begin
      limite = 4'($urandom);
      if (j == ab_m) abort = 1'b1;
      if (j == st_m) begin
        start  = 1'b1;
        limite = st_lim;
      end
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        expq.delete();
        idle_addr = 4'd0;
        break;
      end
    end
    drain(400);
  endtask

  initial begin
    int c;
    int lim;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    idle_addr = 4'd0;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    limite = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;

    tick();
    tick();
    check("rst_leds",   32'(leds),     32'd0);
    check("rst_rgb",    32'(rgb),      32'd0);
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_done",   32'(done),     32'd0);
    check("rst_led_on", 32'(led_on),   32'd0);
    check("rst_addr",   32'(ram_addr), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Full four-entry replay.
    run(3, -1, -1, 4'd0);

    // Single entry: done exactly 8 cycles after the start edge.
    start  = 1'b1;
    limite = 4'd0;
    tick();
    start = 1'b0;
    push_replay(0);
    c = 0;
    while (done !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    check("lim0_done_latency", 32'(c), 32'(ENTRY));
    drain(100);

    // Abort during the third ON phase, then a fresh replay from address 0.
    run(3, 2 * ENTRY + 3, -1, 4'd0);
    run(3, -1, -1, 4'd0);

    // Start pulse with a new limite while busy is ignored.
    run(3, -1, 10, 4'd1);

    // Stored code 0000 still takes an ON slot.
    mem[2] = 4'b0000;
    run(2, -1, -1, 4'd0);
    mem[2] = 4'b0100;

    // Start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    limite = 4'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    idle_addr = 4'd0;
    repeat (4) tick();

    // Async reset in the middle of an ON phase.
    start  = 1'b1;
    limite = 4'd3;
    tick();
    start = 1'b0;
    push_replay(3);
    repeat (4) tick();
    #1;
    reset = 1'b0;
    expq.delete();
    idle_addr = 4'd0;
    #1;
    check("arst_leds",   32'(leds),     32'd0);
    check("arst_rgb",    32'(rgb),      32'd0);
    check("arst_led_on", 32'(led_on),   32'd0);
    check("arst_busy",   32'(busy),     32'd0);
    check("arst_done",   32'(done),     32'd0);
    check("arst_addr",   32'(ram_addr), 32'd0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    run(1, -1, -1, 4'd0);

    // Randomized contents, limits, aborts and stray start pulses.
    for (int r = 0; r < 8; r++) begin
      int n;
      int ab_m;
      int st_m;
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      lim  = $urandom_range(0, 15);
      n    = (lim + 1) * ENTRY + 1;
      ab_m = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
      st_m = $urandom_range(0, n - 3);
      run(lim, ab_m, st_m, 4'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    lim = 15;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run(lim, -1, -1, 4'd0);

    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
